// File: rtl/tft_spi_tx.sv
// tft_spi_tx: byte-level SPI transmitter for the TFT panel.
//
// Accepts one-cycle tft_transmit strobes (with tft_dc/tft_data) from the drawing blocks and
// serialises each byte MSB first on a mode-0 4-wire SPI link. After system reset it drives the
// panel hardware reset sequence: lcd_rst_n low for RST_LOW clocks, then RST_WAIT clocks of settle
// time before the first byte is accepted.
//
// Ports:
//   clk           system clock
//   rst           synchronous, active-high reset
//   tft_transmit  one-cycle strobe, accepted only while tft_busy is low
//   tft_dc        0 = command byte, 1 = data byte
//   tft_data      byte to send
//   tft_busy      high while initialising or shifting
//   spi_sck       SPI clock, idle low
//   spi_mosi      serial data, MSB first
//   spi_cs_n      chip select, active low
//   spi_dc        panel D/C line, held for the whole byte and kept while idle
//   lcd_rst_n     panel hardware reset, active low
module tft_spi_tx #(
   parameter int unsigned DIV      = 2,
   parameter int unsigned RST_LOW  = 1000,
   parameter int unsigned RST_WAIT = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tft_transmit,
   input  logic       tft_dc,
   input  logic [7:0] tft_data,
   output logic       tft_busy,
   output logic       spi_sck,
   output logic       spi_mosi,
   output logic       spi_cs_n,
   output logic       spi_dc,
   output logic       lcd_rst_n
);

   localparam int unsigned MaxA   = (DIV > RST_LOW) ? DIV : RST_LOW;
   localparam int unsigned MaxCnt = (MaxA > RST_WAIT) ? MaxA : RST_WAIT;
   localparam int unsigned CntW   = $clog2(MaxCnt + 1);

   localparam logic [CntW-1:0] DivLast     = CntW'(DIV - 1);
   localparam logic [CntW-1:0] RstLowLast  = CntW'(RST_LOW - 1);
   localparam logic [CntW-1:0] RstWaitLast = CntW'(RST_WAIT - 1);

   typedef enum logic [2:0] {
      StRstHold,
      StRstWait,
      StIdle,
      StSetup,
      StShiftHi,
      StShiftLo,
      StGap
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic            last_q, last_d;
   // Only bits 6..0 are stored; bit 7 goes straight to spi_mosi on accept.
   logic [6:0]      sr_q, sr_d;
   logic            busy_q, busy_d;
   logic            sck_q, sck_d;
   logic            mosi_q, mosi_d;
   logic            cs_n_q, cs_n_d;
   logic            dc_q, dc_d;
   logic            lcd_rst_n_q, lcd_rst_n_d;

   logic div_done;

   assign div_done = (cnt_q == DivLast);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      last_d      = last_q;
      sr_d        = sr_q;
      busy_d      = busy_q;
      sck_d       = sck_q;
      mosi_d      = mosi_q;
      cs_n_d      = cs_n_q;
      dc_d        = dc_q;
      lcd_rst_n_d = lcd_rst_n_q;

      unique case (state_q)
         StRstHold: begin
            if (cnt_q == RstLowLast) begin
               cnt_d       = '0;
               lcd_rst_n_d = 1'b1;
               state_d     = StRstWait;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StRstWait: begin
            if (cnt_q == RstWaitLast) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StIdle: begin
            if (tft_transmit) begin
               sr_d      = tft_data[6:0];
               dc_d      = tft_dc;
               mosi_d    = tft_data[7];
               cs_n_d    = 1'b0;
               busy_d    = 1'b1;
               bit_idx_d = 3'd0;
               last_d    = 1'b0;
               cnt_d     = '0;
               state_d   = StSetup;
            end
         end

         StSetup: begin
            if (div_done) begin
               cnt_d   = '0;
               sck_d   = 1'b1;
               state_d = StShiftHi;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StShiftHi: begin
            if (div_done) begin
               cnt_d   = '0;
               sck_d   = 1'b0;
               state_d = StShiftLo;
               if (bit_idx_q != 3'd7) begin
                  // Next bit changes together with the falling SCK edge.
                  mosi_d    = sr_q[6];
                  sr_d      = {sr_q[5:0], 1'b0};
                  bit_idx_d = bit_idx_q + 3'd1;
               end else begin
                  // Bit 0 has been clocked; the coming low phase is the trailing hold.
                  last_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StShiftLo: begin
            if (div_done) begin
               cnt_d = '0;
               if (last_q) begin
                  last_d  = 1'b0;
                  cs_n_d  = 1'b1;
                  state_d = StGap;
               end else begin
                  sck_d   = 1'b1;
                  state_d = StShiftHi;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StGap: begin
            if (div_done) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         default: begin
            state_d = StRstHold;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRstHold;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         last_q      <= 1'b0;
         sr_q        <= '0;
         busy_q      <= 1'b1;
         sck_q       <= 1'b0;
         mosi_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         dc_q        <= 1'b0;
         lcd_rst_n_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         last_q      <= last_d;
         sr_q        <= sr_d;
         busy_q      <= busy_d;
         sck_q       <= sck_d;
         mosi_q      <= mosi_d;
         cs_n_q      <= cs_n_d;
         dc_q        <= dc_d;
         lcd_rst_n_q <= lcd_rst_n_d;
      end
   end

   assign tft_busy  = busy_q;
   assign spi_sck   = sck_q;
   assign spi_mosi  = mosi_q;
   assign spi_cs_n  = cs_n_q;
   assign spi_dc    = dc_q;
   assign lcd_rst_n = lcd_rst_n_q;

endmodule

// File: doc/tft_spi_tx.md
Name: tft_spi_tx

Overview:
Byte-level SPI transmitter for the TFT panel. It sits directly downstream of the sprite/maze drawing blocks. It consumes their one-cycle tft_transmit/tft_dc/tft_data strobes and returns tft_busy. It serialises each byte onto the panel's 4-wire SPI (SCK, MOSI, CS, DC) and runs the panel's hardware reset sequence after system reset.

Parameters:
DIV, 2, clk cycles per SCK half-period; must be >= 1.
RST_LOW, 1000, clk cycles lcd_rst_n is held low after reset.
RST_WAIT, 1000, clk cycles after lcd_rst_n rises before the first byte is accepted.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
tft_transmit  input  1  one-cycle strobe: accept tft_data/tft_dc
tft_dc  input  1  0 = command byte, 1 = data byte
tft_data  input  8  byte to send
tft_busy  output  1  high while initialising or shifting; the producer strobes only when low
spi_sck  output  1  SPI clock, mode 0 (idle low)
spi_mosi  output  1  serial data, MSB first
spi_cs_n  output  1  chip select, active low
spi_dc  output  1  panel D/C line
lcd_rst_n  output  1  panel hardware reset, active low

Behaviour:
- One clock domain (clk). Synchronous active-high reset (rst). All outputs are registered.
- Reset values: tft_busy=1, spi_sck=0, spi_mosi=0, spi_cs_n=1, spi_dc=0, lcd_rst_n=0. State=RST_HOLD, counters=0.
- FSM states: RST_HOLD -> RST_WAIT -> IDLE -> SETUP -> SHIFT_HI <-> SHIFT_LO -> GAP -> IDLE.
- RST_HOLD:
  - Counts RST_LOW clocks, starting with the first edge where rst=0.
  - On the RST_LOW-th such edge: lcd_rst_n<=1 and go to RST_WAIT.
- RST_WAIT:
  - Counts RST_WAIT clocks.
  - On the last one: tft_busy<=0 and go to IDLE.
- IDLE:
  - tft_busy=0, spi_cs_n=1, spi_sck=0.
  - On an edge sampling tft_transmit=1:
    - latch data into the shift register; spi_dc<=tft_dc; spi_mosi<=tft_data[7]; spi_cs_n<=0;
    - tft_busy<=1 on this same edge, so the producer sees busy=1 the cycle after its strobe;
    - go to SETUP.
- SETUP: hold for DIV clocks (MOSI setup before the first rising SCK edge), then spi_sck<=1 and go to SHIFT_HI.
- SHIFT_HI: hold DIV clocks, then spi_sck<=1'b0.
  - If bit index < 7: shift and present the next bit on spi_mosi; go to SHIFT_LO.
  - If bit 0 has been clocked out: go to SHIFT_LO as the final hold phase.
- SHIFT_LO: hold DIV clocks.
  - If bits remain: spi_sck<=1 and go to SHIFT_HI.
  - Otherwise: spi_cs_n<=1 and go to GAP.
- GAP: hold DIV clocks with CS high, then tft_busy<=0 and go to IDLE.
- Timing per byte:
  - Busy lasts exactly 18*DIV clocks from the strobe edge (SETUP DIV + 16 half-periods + GAP DIV).
  - DIV=2 gives 36 clocks.
  - Eight rising SCK edges per byte; MOSI changes only while SCK is low.
  - spi_dc is stable for the whole time CS is low. spi_dc keeps its last value while idle.
- tft_transmit while tft_busy=1 (including during init) is a protocol violation. The byte is ignored and the in-flight byte is not disturbed.
- A strobe that arrives on the same edge busy falls is not accepted. It must arrive while busy is already low.
- Back-to-back bytes: the next strobe is accepted at the earliest on the cycle after busy falls, so the minimum CS-high time is DIV clocks.
- rst asserted mid-byte or mid-init: all state returns to reset values on that edge. The byte is aborted with CS high and SCK low, and the full panel reset sequence reruns.
- Counter widths are $clog2 of max(DIV, RST_LOW, RST_WAIT)+1. The bit counter is 3 bits.

Test Plan:
- Init (DIV=2, RST_LOW=4, RST_WAIT=6): release rst -> lcd_rst_n rises on the 4th clock edge, tft_busy falls 6 clocks later; spi_cs_n=1, spi_sck=0 throughout.
- Command byte: strobe tft_dc=0, tft_data=8'h2a when idle -> busy=1 on the next cycle; CS low; MOSI sampled at 8 SCK rising edges = 0,0,1,0,1,0,1,0; spi_dc=0; busy high for exactly 36 clocks.
- Data stream: 8'hA5 (dc=1), then 8'h3C (dc=1), each strobed the cycle after busy falls -> decoded bytes A5, 3C; CS high ≥2 clocks between bytes; spi_dc=1.
- Ignored strobe: strobe 8'hFF at clock 10 of a 8'h00 transfer -> output byte stays 00, no extra byte, busy timing unchanged.
- Reset mid-byte: assert rst after 3 SCK rising edges -> next cycle CS=1, SCK=0, lcd_rst_n=0, busy=1; full init repeats before the next byte is accepted.
- DIV=1 corner: send 8'h81 -> 18-clock busy, SCK period 2 clocks, MOSI bits 1,0,0,0,0,0,0,1.
